// File: rtl/sample_dma_pkg.sv
// Shared constants for the sample DMA and its SDRAM neighbour:
// state encoding and SDRAM word-address width.
package sample_dma_pkg;

    localparam int SDRAM_AW  = 24;
    localparam int SAMPLE_DW = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        LATCH = ST_LATCH,
        WRITE = ST_WRITE
    } state_t;

endpackage

// File: rtl/sample_dma_if.sv
// Sample FIFO read port plus SDRAM write channel, as seen by the sample DMA.
interface sample_dma_if
    import sample_dma_pkg::*;
#(
    parameter int AW = SDRAM_AW,
    parameter int DW = SAMPLE_DW
);
    logic          fifo_empty;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data;
    logic          grant;
    logic [AW-1:0] awaddr;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;

    modport master (
        output fifo_rd, awaddr, wdata, wvalid,
        input  fifo_empty, fifo_data, grant, wready
    );

    modport slave (
        input  fifo_rd, awaddr, wdata, wvalid,
        output fifo_empty, fifo_data, grant, wready
    );

endinterface

// File: rtl/sample_dma.sv
// Drains the clock-crossed sample FIFO into a circular SDRAM buffer and
// publishes the producer offset, ring fill level and full flag to the CPU.
//
// state | meaning
// IDLE  | waiting for enable, grant, FIFO data and ring space
// FETCH | fifo_rd high for one cycle
// LATCH | FIFO dout valid; capture data and target address
// WRITE | wvalid held until wready
module sample_dma
    import sample_dma_pkg::*;
#(
    parameter int AW = SDRAM_AW,
    parameter int DW = SAMPLE_DW
) (
    input  logic          clk,
    input  logic          rst,
    sample_dma_if.master  bus,
    input  logic          enable,
    input  logic [AW-1:0] cfg_base,
    input  logic [AW-1:0] cfg_size,
    input  logic [AW-1:0] rd_ptr,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] level,
    output logic          full,
    output logic          cfg_err,
    output logic [31:0]   words
);

    state_t state, state_nx;

    logic          enable_q;
    logic          enable_rise;
    logic          start;
    logic          do_latch;
    logic          do_complete;
    logic          fifo_rd_nx;
    logic          wvalid_nx;
    logic [AW:0]   diff;
    logic [AW:0]   level_ext;
    logic [AW-1:0] size_last;
    logic [AW-1:0] wr_ptr_inc;

    assign enable_rise = enable & ~enable_q;
    assign size_last   = cfg_size - AW'(1);
    assign cfg_err     = enable && (cfg_size < AW'(2));

    // Ring occupancy in AW+1 bits so a negative difference is detectable.
    always_comb begin
        diff      = {1'b0, wr_ptr} - {1'b0, rd_ptr};
        level_ext = diff;
        if (diff[AW]) begin
            level_ext = diff + {1'b0, cfg_size};
        end
    end

    assign level = level_ext[AW-1:0];

    // An out-of-range rd_ptr is a software fault; hold the producer off.
    assign full = (rd_ptr >= cfg_size) || (level == size_last);

    assign wr_ptr_inc = (wr_ptr == size_last) ? '0 : wr_ptr + AW'(1);

    // The cycle the enable edge is sampled only clears the counters.
    assign start = enable && !enable_rise && bus.grant && !bus.fifo_empty
                   && !full && !cfg_err;

    always_comb begin
        state_nx    = state;
        do_latch    = 1'b0;
        do_complete = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                state_nx = LATCH;
            end
            LATCH: begin
                do_latch = 1'b1;
                state_nx = WRITE;
            end
            WRITE: begin
                if (bus.wready) begin
                    do_complete = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        fifo_rd_nx = (state_nx == FETCH);
        wvalid_nx  = (state_nx == WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            enable_q    <= 1'b0;
            bus.fifo_rd <= 1'b0;
            bus.wvalid  <= 1'b0;
            bus.awaddr  <= '0;
            bus.wdata   <= '0;
            wr_ptr      <= '0;
            words       <= '0;
        end else begin
            state       <= state_nx;
            enable_q    <= enable;
            bus.fifo_rd <= fifo_rd_nx;
            bus.wvalid  <= wvalid_nx;
            if (do_latch) begin
                bus.wdata  <= bus.fifo_data;
                bus.awaddr <= cfg_base + wr_ptr;
            end
            if (enable_rise) begin
                wr_ptr <= '0;
                words  <= '0;
            end else if (do_complete) begin
                wr_ptr <= wr_ptr_inc;
                words  <= words + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sample_dma.sv
// Directed and randomized checks of sample_dma against a ring-buffer model
// with behavioural FIFO and SDRAM neighbours.
module tb_sample_dma;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [23:0] cfg_base;
    logic [23:0] cfg_size;
    logic [23:0] rd_ptr;
    logic [23:0] wr_ptr;
    logic [23:0] level;
    logic        full;
    logic        cfg_err;
    logic [31:0] words;

    sample_dma_if bif ();

    sample_dma dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif.master),
        .enable   (enable),
        .cfg_base (cfg_base),
        .cfg_size (cfg_size),
        .rd_ptr   (rd_ptr),
        .wr_ptr   (wr_ptr),
        .level    (level),
        .full     (full),
        .cfg_err  (cfg_err),
        .words    (words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: non-FWFT, data appears the cycle after fifo_rd.
    logic [15:0] mem [0:255];
    int push_cnt = 0;
    int pop_cnt  = 0;

    assign bif.fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (bif.fifo_rd && (push_cnt != pop_cnt)) begin
            bif.fifo_data <= mem[pop_cnt];
            pop_cnt       <= pop_cnt + 1;
        end
    end

    // SDRAM model: log every accepted write.
    logic [23:0] log_a [0:255];
    logic [15:0] log_d [0:255];
    int wr_cnt = 0;

    always @(posedge clk) begin
        if (bif.wvalid && bif.wready) begin
            log_a[wr_cnt] <= bif.awaddr;
            log_d[wr_cnt] <= bif.wdata;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [23:0] m_base;
    int m_size, m_rp, m_wp, m_words, md, wr_chk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        mem[push_cnt] = w;
        push_cnt++;
    endtask

    function automatic int model_level();
        int d;
        d = m_wp - m_rp;
        if (d < 0) d += m_size;
        return d;
    endfunction

    function automatic bit model_full();
        return (m_rp >= m_size) || (model_level() == m_size - 1);
    endfunction

    task automatic model_restart(input logic [23:0] base, input int size, input int rp);
        m_base   = base;
        m_size   = size;
        m_rp     = rp;
        m_wp     = 0;
        m_words  = 0;
        cfg_base = base;
        cfg_size = 24'(size);
        rd_ptr   = 24'(rp);
    endtask

    task automatic check_new_writes();
        for (int k = wr_chk; k < wr_cnt; k++) begin
            check("wr_addr", log_a[k], m_base + 24'(m_wp));
            check("wr_data", log_d[k], mem[md]);
            md++;
            m_wp = (m_wp + 1) % m_size;
            m_words++;
        end
        wr_chk = wr_cnt;
    endtask

    task automatic check_status();
        check("wr_ptr",  wr_ptr,  64'(m_wp));
        check("level",   level,   64'(model_level()));
        check("full",    full,    64'(model_full()));
        check("words",   words,   64'(m_words));
        check("cfg_err", cfg_err, 64'(enable && (m_size < 2)));
    endtask

    task automatic drain(input int n, input bit consume);
        int target, start_wp, live_wp;
        target   = wr_chk + n;
        start_wp = m_wp;
        for (int c = 0; c < n * 60 + 100 && wr_cnt < target; c++) begin
            bif.grant  = 1'($urandom_range(0, 1));
            bif.wready = ($urandom_range(0, 3) != 0);
            if (consume && $urandom_range(0, 3) == 0) begin
                live_wp = (start_wp + (wr_cnt - wr_chk)) % m_size;
                if (live_wp != m_rp) begin
                    m_rp   = (m_rp + 1) % m_size;
                    rd_ptr = 24'(m_rp);
                end
            end
            tick();
        end
        bif.grant  = 1'b0;
        bif.wready = 1'b0;
        check("drain_cnt", wr_cnt, target);
        check_new_writes();
    endtask

    task automatic wait_wvalid();
        for (int c = 0; c < 30 && !bif.wvalid; c++) tick();
        check("wvalid_seen", bif.wvalid, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a0;
        logic [15:0] d0;
        int pb;

        rst        = 1'b1;
        enable     = 1'b0;
        bif.grant  = 1'b0;
        bif.wready = 1'b0;
        md         = 0;
        wr_chk     = 0;
        model_restart(24'h0, 8, 0);
        tick();
        tick();
        check("rst_wvalid",  bif.wvalid,  0);
        check("rst_fifo_rd", bif.fifo_rd, 0);
        check("rst_wr_ptr",  wr_ptr,      0);
        check("rst_words",   words,       0);
        check("rst_awaddr",  bif.awaddr,  0);
        check("rst_wdata",   bif.wdata,   0);
        rst = 1'b0;
        tick();

        // Basic base/size setup.
        model_restart(24'h100000, 8, 0);
        enable = 1'b1;
        tick();
        push(16'hA001);
        push(16'hA002);
        push(16'hA003);
        drain(3, 1'b0);
        check_status();

        // Wrap and full back-pressure.
        enable = 1'b0;
        tick();
        model_restart(24'($urandom), 4, 0);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) push(16'($urandom));
        drain(3, 1'b0);
        bif.grant  = 1'b1;
        bif.wready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("full_no_write", wr_cnt, wr_chk);
        check("fifo_left", push_cnt - pop_cnt, 2);
        check_status();
        m_rp   = 2;
        rd_ptr = 24'd2;
        drain(2, 1'b0);
        check_status();

        // Stalled write: outputs hold whatever grant does.
        m_rp       = 1;
        rd_ptr     = 24'd1;
        bif.grant  = 1'b1;
        bif.wready = 1'b0;
        pb         = pop_cnt;
        push(16'($urandom));
        wait_wvalid();
        a0 = bif.awaddr;
        d0 = bif.wdata;
        check("bp_addr", a0, m_base + 24'(m_wp));
        check("bp_data", d0, mem[md]);
        for (int i = 0; i < 10; i++) begin
            bif.grant = 1'($urandom_range(0, 1));
            tick();
            check("bp_hold", {bif.wvalid, bif.awaddr, bif.wdata}, {1'b1, a0, d0});
        end
        check("bp_one_read", pop_cnt - pb, 1);
        bif.wready = 1'b1;
        tick();
        bif.wready = 1'b0;
        bif.grant  = 1'b0;
        check("bp_done", wr_cnt, wr_chk + 1);
        check_new_writes();
        check_status();

        // Enable falls during LATCH: that word finishes, nothing more is read.
        bif.grant  = 1'b1;
        bif.wready = 1'b1;
        pb         = pop_cnt;
        push(16'($urandom));
        push(16'($urandom));
        for (int c = 0; c < 30 && !bif.fifo_rd; c++) tick();
        check("fetch_seen", bif.fifo_rd, 1);
        tick();
        enable = 1'b0;
        drain(1, 1'b0);
        bif.grant  = 1'b1;
        bif.wready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("dis_one_read", pop_cnt - pb, 1);
        check("dis_no_write", wr_cnt, wr_chk);
        bif.grant = 1'b0;
        model_restart(m_base, 4, 0);
        enable = 1'b1;
        tick();
        check_status();
        drain(1, 1'b0);
        check_status();

        // Degenerate ring size.
        enable = 1'b0;
        tick();
        model_restart(m_base, 1, 0);
        enable     = 1'b1;
        bif.grant  = 1'b1;
        bif.wready = 1'b1;
        pb         = pop_cnt;
        push(16'($urandom));
        for (int i = 0; i < 15; i++) tick();
        check("err_no_read", pop_cnt - pb, 0);
        check_status();
        enable = 1'b0;
        bif.grant = 1'b0;
        tick();
        model_restart(m_base, 2, 0);
        enable = 1'b1;
        drain(1, 1'b0);
        check_status();
        m_rp   = 2;
        rd_ptr = 24'd2;
        tick();
        check_status();
        m_rp   = 1;
        rd_ptr = 24'd1;
        tick();
        check_status();

        // Reset while a write is stalled: the in-flight word is lost.
        bif.grant  = 1'b1;
        bif.wready = 1'b0;
        push(16'($urandom));
        wait_wvalid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_wvalid",  bif.wvalid,  0);
        check("rstw_fifo_rd", bif.fifo_rd, 0);
        check("rstw_wr_ptr",  wr_ptr,      0);
        check("rstw_words",   words,       0);
        md++;
        model_restart(m_base, 2, 0);
        tick();
        check("rstw_no_write", wr_cnt, wr_chk);
        push(16'($urandom));
        drain(1, 1'b0);
        check_status();

        // Randomized run with a live consumer, base near the top of memory.
        enable = 1'b0;
        tick();
        model_restart(24'hFFFFF0 | 24'($urandom_range(0, 15)), $urandom_range(5, 12), 0);
        enable = 1'b1;
        for (int i = 0; i < 20; i++) push(16'($urandom));
        drain(20, 1'b1);
        tick();
        check_status();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
